// File: rtl/out_port_sched_pkg.sv
// Shared types, port-index constants and rotation helpers for the per-output-port scheduler.
package out_port_sched_pkg;

    localparam int NUM_PORTS = 5;
    localparam int SEL_W     = 3;

    typedef logic [NUM_PORTS-1:0] port_vec_t;
    typedef logic [SEL_W-1:0]     port_idx_t;

    // Bit order of every request/grant vector: [4]=N [3]=S [2]=E [1]=W [0]=PE
    localparam port_idx_t P_N  = 3'd4;
    localparam port_idx_t P_S  = 3'd3;
    localparam port_idx_t P_E  = 3'd2;
    localparam port_idx_t P_W  = 3'd1;
    localparam port_idx_t P_PE = 3'd0;

    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_e;

    // Next port in the downward rotation N->S->E->W->PE->N.
    function automatic port_idx_t rot_succ(input port_idx_t idx);
        return (idx == P_PE) ? P_N : idx - 3'd1;
    endfunction

    function automatic port_vec_t idx_to_oh(input port_idx_t idx);
        port_vec_t oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/out_port_sched_if.sv
// Request/grant bundle between the five input ports and one output-port scheduler.
interface out_port_sched_if;
    import out_port_sched_pkg::*;

    logic       polarity;
    port_vec_t  req_vc0;
    port_vec_t  req_vc1;
    logic [1:0] outbuf_full;
    port_vec_t  gnt;
    logic       gnt_vc;
    logic       gnt_valid;
    port_idx_t  xbar_sel;

    modport master (
        output polarity, req_vc0, req_vc1, outbuf_full,
        input  gnt, gnt_vc, gnt_valid, xbar_sel
    );

    modport slave (
        input  polarity, req_vc0, req_vc1, outbuf_full,
        output gnt, gnt_vc, gnt_valid, xbar_sel
    );

endinterface

// File: rtl/out_port_sched_rr_pick5.sv
// Combinational round-robin picker: first set request at or below the pointer, wrapping PE->N.
module rr_pick5
    import out_port_sched_pkg::*;
(
    input  port_vec_t req_i,
    input  port_vec_t ptr_i,
    output port_vec_t win_oh_o,
    output port_idx_t win_idx_o,
    output logic      found_o
);

    port_idx_t start;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        start = P_N;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ptr_i[i]) start = port_idx_t'(i);
        end
    end

    always_comb begin
        int        j;
        port_idx_t cand;
        logic      found;
        j         = 0;
        cand      = '0;
        found     = 1'b0;
        win_oh_o  = '0;
        win_idx_o = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(start) - k;
            if (j < 0) j = j + NUM_PORTS;
            cand = port_idx_t'(j);
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                win_idx_o = cand;
                win_oh_o  = idx_to_oh(cand);
            end
        end
        found_o = found;
    end

endmodule

// File: rtl/out_port_sched.sv
// Output-port scheduler: serves one VC per cycle (chosen by polarity) with an independent
// round-robin pointer per VC, issuing registered one-hot grants and crossbar select.
module out_port_sched
    import out_port_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    out_port_sched_if.slave  bus
);

    port_idx_t ptr0_q, ptr0_d;
    port_idx_t ptr1_q, ptr1_d;
    port_vec_t gnt_q, gnt_d;
    vc_e       gnt_vc_q, gnt_vc_d;
    logic      gnt_valid_q, gnt_valid_d;
    port_idx_t xbar_sel_q, xbar_sel_d;

    port_vec_t win0_oh, win1_oh;
    port_idx_t win0_idx, win1_idx;
    logic      found0, found1;

    rr_pick5 u_pick_vc0 (
        .req_i     (bus.req_vc0),
        .ptr_i     (idx_to_oh(ptr0_q)),
        .win_oh_o  (win0_oh),
        .win_idx_o (win0_idx),
        .found_o   (found0)
    );

    rr_pick5 u_pick_vc1 (
        .req_i     (bus.req_vc1),
        .ptr_i     (idx_to_oh(ptr1_q)),
        .win_oh_o  (win1_oh),
        .win_idx_o (win1_idx),
        .found_o   (found1)
    );

    vc_e       vc_sel;
    logic      eligible;
    port_vec_t win_oh;
    port_idx_t win_idx;

    always_comb begin
        vc_sel   = vc_e'(bus.polarity);
        win_oh   = (vc_sel == VC1) ? win1_oh  : win0_oh;
        win_idx  = (vc_sel == VC1) ? win1_idx : win0_idx;
        // A full output buffer on the served VC overrides any request arriving with it.
        eligible = ((vc_sel == VC1) ? found1 : found0) && !bus.outbuf_full[vc_sel];

        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_vc_d    = gnt_vc_q;
        xbar_sel_d  = xbar_sel_q;
        ptr0_d      = ptr0_q;
        ptr1_d      = ptr1_q;

        if (eligible) begin
            gnt_d       = win_oh;
            gnt_valid_d = 1'b1;
            gnt_vc_d    = vc_sel;
            xbar_sel_d  = win_idx;
            if (vc_sel == VC1) ptr1_d = rot_succ(win_idx);
            else               ptr0_d = rot_succ(win_idx);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q       <= '0;
            gnt_vc_q    <= VC0;
            gnt_valid_q <= 1'b0;
            xbar_sel_q  <= '0;
            ptr0_q      <= P_N;
            ptr1_q      <= P_N;
        end else begin
            gnt_q       <= gnt_d;
            gnt_vc_q    <= gnt_vc_d;
            gnt_valid_q <= gnt_valid_d;
            xbar_sel_q  <= xbar_sel_d;
            ptr0_q      <= ptr0_d;
            ptr1_q      <= ptr1_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_vc    = gnt_vc_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.xbar_sel  = xbar_sel_q;

endmodule

// File: tb/tb_out_port_sched.sv
// Directed-vector bench for out_port_sched with hand-computed grant sequences.
module tb_out_port_sched;
    import out_port_sched_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    out_port_sched_if bus ();

    out_port_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus, let the edge pass, then sample 1 time unit later.
    task automatic step(input logic rst, input logic pol, input port_vec_t r0,
                        input port_vec_t r1, input logic [1:0] full);
        reset           = rst;
        bus.polarity    = pol;
        bus.req_vc0     = r0;
        bus.req_vc1     = r1;
        bus.outbuf_full = full;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input port_vec_t e_gnt, input logic e_vc,
                       input logic e_valid, input port_idx_t e_sel);
        vectors = vectors + 4;
        assert (bus.gnt === e_gnt) else begin
            miscompares++;
            $error("FAIL %s gnt: got %b expected %b", tag, bus.gnt, e_gnt);
        end
        assert (bus.gnt_vc === e_vc) else begin
            miscompares++;
            $error("FAIL %s gnt_vc: got %b expected %b", tag, bus.gnt_vc, e_vc);
        end
        assert (bus.gnt_valid === e_valid) else begin
            miscompares++;
            $error("FAIL %s gnt_valid: got %b expected %b", tag, bus.gnt_valid, e_valid);
        end
        assert (bus.xbar_sel === e_sel) else begin
            miscompares++;
            $error("FAIL %s xbar_sel: got %0d expected %0d", tag, bus.xbar_sel, e_sel);
        end
    endtask

    initial begin
        bus.polarity    = 1'b0;
        bus.req_vc0     = '0;
        bus.req_vc1     = '0;
        bus.outbuf_full = 2'b00;

        // 1) reset, no requests
        step(1'b1, 1'b0, 5'b00000, 5'b00000, 2'b00); chk("rst0", 5'b00000, VC0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 5'b00000, 5'b00000, 2'b00); chk("rst1", 5'b00000, VC0, 1'b0, 3'd0);

        // 2) single requester E on VC0, granted on every VC0 phase
        step(1'b0, 1'b0, 5'b00100, 5'b00000, 2'b00); chk("e_a",   5'b00100, VC0, 1'b1, P_E);
        step(1'b0, 1'b1, 5'b00100, 5'b00000, 2'b00); chk("e_v1a", 5'b00000, VC0, 1'b0, P_E);
        step(1'b0, 1'b0, 5'b00100, 5'b00000, 2'b00); chk("e_b",   5'b00100, VC0, 1'b1, P_E);
        step(1'b0, 1'b1, 5'b00100, 5'b00000, 2'b00); chk("e_v1b", 5'b00000, VC0, 1'b0, P_E);
        step(1'b0, 1'b0, 5'b00100, 5'b00000, 2'b00); chk("e_c",   5'b00100, VC0, 1'b1, P_E);

        // re-home both pointers to N
        step(1'b1, 1'b0, 5'b00000, 5'b00000, 2'b00); chk("rst2", 5'b00000, VC0, 1'b0, 3'd0);

        // 3) full contention, interleaved independent rotations
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b00); chk("c0_n",  5'b10000, VC0, 1'b1, P_N);
        step(1'b0, 1'b1, 5'b11111, 5'b11111, 2'b00); chk("c1_n",  5'b10000, VC1, 1'b1, P_N);
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b00); chk("c0_s",  5'b01000, VC0, 1'b1, P_S);
        step(1'b0, 1'b1, 5'b11111, 5'b11111, 2'b00); chk("c1_s",  5'b01000, VC1, 1'b1, P_S);
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b00); chk("c0_e",  5'b00100, VC0, 1'b1, P_E);
        step(1'b0, 1'b1, 5'b11111, 5'b11111, 2'b00); chk("c1_e",  5'b00100, VC1, 1'b1, P_E);
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b00); chk("c0_w",  5'b00010, VC0, 1'b1, P_W);
        step(1'b0, 1'b1, 5'b11111, 5'b11111, 2'b00); chk("c1_w",  5'b00010, VC1, 1'b1, P_W);
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b00); chk("c0_pe", 5'b00001, VC0, 1'b1, P_PE);
        step(1'b0, 1'b1, 5'b11111, 5'b11111, 2'b00); chk("c1_pe", 5'b00001, VC1, 1'b1, P_PE);
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b00); chk("c0_n2", 5'b10000, VC0, 1'b1, P_N);
        step(1'b0, 1'b1, 5'b11111, 5'b11111, 2'b00); chk("c1_n2", 5'b10000, VC1, 1'b1, P_N);
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b00); chk("c0_s2", 5'b01000, VC0, 1'b1, P_S);

        // 4) VC0 buffer full for two VC0 phases; VC1 keeps rotating
        step(1'b0, 1'b1, 5'b11111, 5'b11111, 2'b01); chk("f1_s",  5'b01000, VC1, 1'b1, P_S);
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b01); chk("f0_a",  5'b00000, VC1, 1'b0, P_S);
        step(1'b0, 1'b1, 5'b11111, 5'b11111, 2'b01); chk("f1_e",  5'b00100, VC1, 1'b1, P_E);
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b01); chk("f0_b",  5'b00000, VC1, 1'b0, P_E);
        step(1'b0, 1'b1, 5'b11111, 5'b11111, 2'b00); chk("f1_w",  5'b00010, VC1, 1'b1, P_W);
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b00); chk("f0_e",  5'b00100, VC0, 1'b1, P_E);

        // 5) VC1 requesters N and PE, pointer at PE: wrap behaviour
        step(1'b0, 1'b1, 5'b00000, 5'b10001, 2'b00); chk("w_pe",  5'b00001, VC1, 1'b1, P_PE);
        step(1'b0, 1'b0, 5'b00000, 5'b10001, 2'b00); chk("w_v0a", 5'b00000, VC1, 1'b0, P_PE);
        step(1'b0, 1'b1, 5'b00000, 5'b10001, 2'b00); chk("w_n",   5'b10000, VC1, 1'b1, P_N);
        step(1'b0, 1'b0, 5'b00000, 5'b10001, 2'b00); chk("w_v0b", 5'b00000, VC1, 1'b0, P_N);
        step(1'b0, 1'b1, 5'b00000, 5'b10001, 2'b00); chk("w_pe2", 5'b00001, VC1, 1'b1, P_PE);
        // full and request together on VC1: full wins, pointer stays put
        step(1'b0, 1'b1, 5'b00000, 5'b10001, 2'b10); chk("w_full", 5'b00000, VC1, 1'b0, P_PE);
        step(1'b0, 1'b1, 5'b00000, 5'b10001, 2'b00); chk("w_n2",  5'b10000, VC1, 1'b1, P_N);

        // 6) reset pulse during full contention
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b00); chk("r_w",   5'b00010, VC0, 1'b1, P_W);
        step(1'b1, 1'b1, 5'b11111, 5'b11111, 2'b00); chk("r_rst", 5'b00000, VC0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 5'b11111, 5'b11111, 2'b00); chk("r_n0",  5'b10000, VC0, 1'b1, P_N);
        step(1'b0, 1'b1, 5'b11111, 5'b11111, 2'b00); chk("r_n1",  5'b10000, VC1, 1'b1, P_N);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
